// File: rtl/tdm_frame_counter_pkg.sv
// Shared types and width helper for the TDM frame counter.
package tdm_cnt_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} tdm_cnt_state_t;

  function automatic int cnt_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdm_frame_counter_if.sv
// Control inputs, indices and strobes of the TDM timebase.
interface tdm_frame_counter_if #(
  parameter int SLOT_CYCLES = 8,
  parameter int NUM_SLOTS   = 4,
  parameter int NUM_FRAMES  = 16
);
  import tdm_cnt_pkg::*;

  localparam int CW = cnt_w(SLOT_CYCLES);
  localparam int SW = cnt_w(NUM_SLOTS);
  localparam int FW = cnt_w(NUM_FRAMES);

  logic          en;
  logic          start;
  logic          clear;
  logic [CW-1:0] cyc_idx;
  logic [SW-1:0] slot_idx;
  logic [FW-1:0] frame_idx;
  logic          active;
  logic          slot_start;
  logic          slot_last;
  logic          frame_start;
  logic          frame_last;
  logic          seq_done;

  modport master (
    output en, start, clear,
    input  cyc_idx, slot_idx, frame_idx, active,
    input  slot_start, slot_last, frame_start, frame_last, seq_done
  );

  modport slave (
    input  en, start, clear,
    output cyc_idx, slot_idx, frame_idx, active,
    output slot_start, slot_last, frame_start, frame_last, seq_done
  );

endinterface

// File: rtl/tdm_frame_counter_wrap.sv
// Modulo-N counter; `wrap` carries into the next level of the chain.
module wrap_counter
  import tdm_cnt_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  output logic [cnt_w(N)-1:0] q,
  output logic                last,
  output logic                wrap
);

  localparam int             W   = cnt_w(N);
  localparam logic [W-1:0]   MAX = W'(N - 1);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = last ? '0 : q_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q    = q_q;
  assign last = (q_q == MAX);
  assign wrap = last && inc;

endmodule

// File: rtl/tdm_frame_counter.sv
// Three-level TDM timebase: beat/slot/frame counters, run FSM and strobe decode.
module tdm_frame_counter
  import tdm_cnt_pkg::*;
#(
  parameter int SLOT_CYCLES = 8,
  parameter int NUM_SLOTS   = 4,
  parameter int NUM_FRAMES  = 16,
  parameter int ONE_SHOT    = 0
) (
  input  logic                clk,
  input  logic                rst,
  tdm_frame_counter_if.slave  bus
);

  localparam int CW = cnt_w(SLOT_CYCLES);
  localparam int SW = cnt_w(NUM_SLOTS);
  localparam int FW = cnt_w(NUM_FRAMES);

  if (SLOT_CYCLES < 1 || NUM_SLOTS < 1 || NUM_FRAMES < 1) begin : g_bad_param
    $error("tdm_frame_counter: count parameters must all be >= 1");
  end

  tdm_cnt_state_t state_q, state_d;
  logic           seq_done_q, seq_done_d;
  logic           active, adv;
  logic           cyc_last, slot_last_w, cyc_wrap, slot_wrap, final_beat;
  logic           frame_last_unused;
  logic [CW-1:0]  cyc_q;
  logic [SW-1:0]  slot_q;
  logic [FW-1:0]  frame_q;

  assign active = (state_q == RUN);
  // clear outranks advance, so it also suppresses the final beat
  assign adv    = active && bus.en && !bus.clear;

  wrap_counter #(.N(SLOT_CYCLES)) u_cyc (
    .clk(clk), .rst(rst), .clr(bus.clear), .inc(adv),
    .q(cyc_q), .last(cyc_last), .wrap(cyc_wrap)
  );

  wrap_counter #(.N(NUM_SLOTS)) u_slot (
    .clk(clk), .rst(rst), .clr(bus.clear), .inc(cyc_wrap),
    .q(slot_q), .last(slot_last_w), .wrap(slot_wrap)
  );

  wrap_counter #(.N(NUM_FRAMES)) u_frame (
    .clk(clk), .rst(rst), .clr(bus.clear), .inc(slot_wrap),
    .q(frame_q), .last(frame_last_unused), .wrap(final_beat)
  );

  always_comb begin
    state_d    = state_q;
    seq_done_d = final_beat;
    case (state_q)
      IDLE: begin
        if (ONE_SHOT == 0)                state_d = RUN;
        else if (bus.start && !bus.clear) state_d = RUN;
      end
      RUN: begin
        if (ONE_SHOT != 0 && final_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_done_q <= seq_done_d;
    end
  end

  assign bus.cyc_idx     = cyc_q;
  assign bus.slot_idx    = slot_q;
  assign bus.frame_idx   = frame_q;
  assign bus.active      = active;
  assign bus.slot_start  = active && (cyc_q == '0);
  assign bus.slot_last   = active && cyc_last;
  assign bus.frame_start = active && (cyc_q == '0) && (slot_q == '0);
  assign bus.frame_last  = active && cyc_last && slot_last_w;
  assign bus.seq_done    = seq_done_q;

endmodule

// File: tb/tb_tdm_frame_counter.sv
// Bench for tdm_frame_counter: four configurations against a beat-position model.
module tb_tdm_frame_counter;

  localparam int SC [4] = '{8, 8, 1, 2};
  localparam int NS [4] = '{4, 4, 1, 5};
  localparam int NF [4] = '{16, 16, 3, 2};
  localparam int OS [4] = '{0, 1, 0, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_v [4];
  logic en_v [4];
  logic start_v [4];
  logic clear_v [4];

  int cyc_a [4], slot_a [4], frame_a [4], act_a [4];
  int ss_a [4], sl_a [4], fs_a [4], fl_a [4], done_a [4];

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;
  int max_slot3 = 0;

  // model state: running flag, linear beat position in the sequence, done pulse
  int m_act [4] = '{0, 0, 0, 0};
  int m_b [4] = '{0, 0, 0, 0};
  int m_done [4] = '{0, 0, 0, 0};

  tdm_frame_counter_if #(.SLOT_CYCLES(8), .NUM_SLOTS(4), .NUM_FRAMES(16)) if0 ();
  tdm_frame_counter_if #(.SLOT_CYCLES(8), .NUM_SLOTS(4), .NUM_FRAMES(16)) if1 ();
  tdm_frame_counter_if #(.SLOT_CYCLES(1), .NUM_SLOTS(1), .NUM_FRAMES(3)) if2 ();
  tdm_frame_counter_if #(.SLOT_CYCLES(2), .NUM_SLOTS(5), .NUM_FRAMES(2)) if3 ();

  tdm_frame_counter #(.SLOT_CYCLES(8), .NUM_SLOTS(4), .NUM_FRAMES(16), .ONE_SHOT(0))
    u0 (.clk(clk), .rst(rst_v[0]), .bus(if0.slave));
  tdm_frame_counter #(.SLOT_CYCLES(8), .NUM_SLOTS(4), .NUM_FRAMES(16), .ONE_SHOT(1))
    u1 (.clk(clk), .rst(rst_v[1]), .bus(if1.slave));
  tdm_frame_counter #(.SLOT_CYCLES(1), .NUM_SLOTS(1), .NUM_FRAMES(3), .ONE_SHOT(0))
    u2 (.clk(clk), .rst(rst_v[2]), .bus(if2.slave));
  tdm_frame_counter #(.SLOT_CYCLES(2), .NUM_SLOTS(5), .NUM_FRAMES(2), .ONE_SHOT(0))
    u3 (.clk(clk), .rst(rst_v[3]), .bus(if3.slave));

  assign if0.en = en_v[0]; assign if0.start = start_v[0]; assign if0.clear = clear_v[0];
  assign if1.en = en_v[1]; assign if1.start = start_v[1]; assign if1.clear = clear_v[1];
  assign if2.en = en_v[2]; assign if2.start = start_v[2]; assign if2.clear = clear_v[2];
  assign if3.en = en_v[3]; assign if3.start = start_v[3]; assign if3.clear = clear_v[3];

  assign cyc_a[0] = int'(if0.cyc_idx); assign slot_a[0] = int'(if0.slot_idx);
  assign frame_a[0] = int'(if0.frame_idx); assign act_a[0] = int'(if0.active);
  assign ss_a[0] = int'(if0.slot_start); assign sl_a[0] = int'(if0.slot_last);
  assign fs_a[0] = int'(if0.frame_start); assign fl_a[0] = int'(if0.frame_last);
  assign done_a[0] = int'(if0.seq_done);

  assign cyc_a[1] = int'(if1.cyc_idx); assign slot_a[1] = int'(if1.slot_idx);
  assign frame_a[1] = int'(if1.frame_idx); assign act_a[1] = int'(if1.active);
  assign ss_a[1] = int'(if1.slot_start); assign sl_a[1] = int'(if1.slot_last);
  assign fs_a[1] = int'(if1.frame_start); assign fl_a[1] = int'(if1.frame_last);
  assign done_a[1] = int'(if1.seq_done);

  assign cyc_a[2] = int'(if2.cyc_idx); assign slot_a[2] = int'(if2.slot_idx);
  assign frame_a[2] = int'(if2.frame_idx); assign act_a[2] = int'(if2.active);
  assign ss_a[2] = int'(if2.slot_start); assign sl_a[2] = int'(if2.slot_last);
  assign fs_a[2] = int'(if2.frame_start); assign fl_a[2] = int'(if2.frame_last);
  assign done_a[2] = int'(if2.seq_done);

  assign cyc_a[3] = int'(if3.cyc_idx); assign slot_a[3] = int'(if3.slot_idx);
  assign frame_a[3] = int'(if3.frame_idx); assign act_a[3] = int'(if3.active);
  assign ss_a[3] = int'(if3.slot_start); assign sl_a[3] = int'(if3.slot_last);
  assign fs_a[3] = int'(if3.frame_start); assign fl_a[3] = int'(if3.frame_last);
  assign done_a[3] = int'(if3.seq_done);

  task automatic chk(input string nm, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // steps until instance i shows seq_done; k is the number of cycles waited
  task automatic wait_done(input int i, input int maxc, input bit toggle, output int k);
    k = 0;
    do begin
      if (toggle) en_v[i] = ~en_v[i];
      step(1);
      k++;
    end while (done_a[i] == 0 && k < maxc);
  endtask

  // sequence model: one beat position per advance, indices derived arithmetically
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      automatic int tot = SC[i] * NS[i] * NF[i];
      automatic int b = m_b[i];
      automatic int a = m_act[i];
      automatic int d = 0;
      if (rst_v[i]) begin
        a = 0; b = 0;
      end else if (a == 0) begin
        if (OS[i] == 0) a = 1;
        else if (start_v[i] && !clear_v[i]) begin a = 1; b = 0; end
        if (clear_v[i]) b = 0;
      end else if (clear_v[i]) begin
        b = 0;
      end else if (en_v[i]) begin
        if (b == tot - 1) begin
          b = 0; d = 1;
          if (OS[i] != 0) a = 0;
        end else begin
          b = b + 1;
        end
      end
      m_b[i] <= b;
      m_act[i] <= a;
      m_done[i] <= d;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 4; i++) begin
        automatic int c = m_b[i] % SC[i];
        automatic int s = (m_b[i] / SC[i]) % NS[i];
        automatic int f = m_b[i] / (SC[i] * NS[i]);
        automatic int a = m_act[i];
        automatic int ss = (a != 0 && c == 0) ? 1 : 0;
        automatic int sl = (a != 0 && c == SC[i] - 1) ? 1 : 0;
        chk($sformatf("i%0d cyc_idx", i), cyc_a[i], c);
        chk($sformatf("i%0d slot_idx", i), slot_a[i], s);
        chk($sformatf("i%0d frame_idx", i), frame_a[i], f);
        chk($sformatf("i%0d active", i), act_a[i], a);
        chk($sformatf("i%0d slot_start", i), ss_a[i], ss);
        chk($sformatf("i%0d slot_last", i), sl_a[i], sl);
        chk($sformatf("i%0d frame_start", i), fs_a[i], (ss != 0 && s == 0) ? 1 : 0);
        chk($sformatf("i%0d frame_last", i), fl_a[i], (sl != 0 && s == NS[i] - 1) ? 1 : 0);
        chk($sformatf("i%0d seq_done", i), done_a[i], m_done[i]);
      end
      if (slot_a[3] > max_slot3) max_slot3 <= slot_a[3];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 4; i++) begin
      rst_v[i] = 1'b1; en_v[i] = 1'b1; start_v[i] = 1'b0; clear_v[i] = 1'b0;
    end
    step(2);
    chk_on = 1'b1;
    chk("reset active", act_a[0], 0);
    chk("reset slot_start", ss_a[0], 0);
    chk("reset seq_done", done_a[0], 0);
    for (int i = 0; i < 4; i++) rst_v[i] = 1'b0;

    // free-run timing
    step(1);
    chk("free-run active after release", act_a[0], 1);
    chk("one-shot idle before start", act_a[1], 0);
    chk("degenerate strobe slot_start", ss_a[2], 1);
    chk("degenerate strobe frame_last", fl_a[2], 1);
    wait_done(0, 600, 1'b0, k);
    chk("first seq_done cycle", k, 512);
    wait_done(0, 600, 1'b0, k);
    chk("seq_done period", k, 512);

    // clear mid-sequence and on the final beat
    step(179);
    chk("pre-clear cyc", cyc_a[0], 3);
    chk("pre-clear slot", slot_a[0], 2);
    chk("pre-clear frame", frame_a[0], 5);
    clear_v[0] = 1'b1; step(1); clear_v[0] = 1'b0;
    chk("clear cyc", cyc_a[0], 0);
    chk("clear frame", frame_a[0], 0);
    chk("clear keeps active", act_a[0], 1);
    step(511);
    chk("final-beat frame", frame_a[0], 15);
    chk("final-beat cyc", cyc_a[0], 7);
    clear_v[0] = 1'b1; step(1); clear_v[0] = 1'b0;
    chk("clear on final beat no done", done_a[0], 0);
    step(1);
    chk("clear on final beat no late done", done_a[0], 0);
    chk("advance after clear", cyc_a[0], 1);

    // reset mid-sequence
    step(11);
    chk("pre-rst cyc", cyc_a[0], 4);
    chk("pre-rst slot", slot_a[0], 1);
    rst_v[0] = 1'b1; step(1); rst_v[0] = 1'b0;
    chk("rst active", act_a[0], 0);
    chk("rst cyc", cyc_a[0], 0);
    chk("rst slot", slot_a[0], 0);
    chk("rst slot_start", ss_a[0], 0);
    chk("rst seq_done", done_a[0], 0);
    step(1);
    chk("active after rst release", act_a[0], 1);

    // en at 50% duty
    wait_done(0, 1100, 1'b1, k);
    wait_done(0, 1100, 1'b1, k);
    chk("half-duty sequence length", k, 1024);
    en_v[0] = 1'b1;

    // one-shot with a mid-run start pulse
    chk("one-shot idle cyc", cyc_a[1], 0);
    start_v[1] = 1'b1; step(1); start_v[1] = 1'b0;
    chk("one-shot active after start", act_a[1], 1);
    k = 0;
    do begin
      k++;
      start_v[1] = (k == 100);
      step(1);
    end while (done_a[1] == 0 && k < 600);
    start_v[1] = 1'b0;
    chk("one-shot length", k, 512);
    chk("one-shot inactive with done", act_a[1], 0);

    // start held high: back-to-back sequences
    start_v[1] = 1'b1;
    step(1);
    chk("back-to-back restart", act_a[1], 1);
    wait_done(1, 600, 1'b0, k);
    chk("held-start length", k, 512);
    chk("held-start idle cycle", act_a[1], 0);
    step(1);
    chk("held-start gap one cycle", act_a[1], 1);
    start_v[1] = 1'b0;

    // degenerate 1x1x3 frame walk
    clear_v[2] = 1'b1; step(1); clear_v[2] = 1'b0;
    chk("deg frame 0", frame_a[2], 0);
    step(1);
    chk("deg frame 1", frame_a[2], 1);
    step(1);
    chk("deg frame 2", frame_a[2], 2);
    step(1);
    chk("deg frame wrap", frame_a[2], 0);
    chk("deg seq_done every 3", done_a[2], 1);

    step(1);
    chk("five-slot max index", max_slot3, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_frame_counter.md
# tdm_frame_counter

Parametrised three-level TDM timebase: cycle-within-slot, slot-within-frame, and frame-within-sequence counters, with enable, synchronous clear, free-run or one-shot mode, and decoded slot/frame boundary strobes. It replaces the single wrapping incrementer as the timing source for burst slot muxing. Downstream burst formatters consume its indices and strobes directly.

## Interface
- SLOT_CYCLES, default 8: clock beats per slot, ≥1.
- NUM_SLOTS, default 4: slots per frame, ≥1.
- NUM_FRAMES, default 16: frames per sequence, ≥1.
- ONE_SHOT, default 0: 0 = free-run after reset; 1 = run one sequence per `start`.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance enable; when low, all counters hold.
- start  in  1  one-shot trigger; ignored when ONE_SHOT=0.
- clear  in  1  synchronous counter clear; state is unchanged.
- cyc_idx  out  CW  beat index in slot, 0..SLOT_CYCLES-1.
- slot_idx  out  SW  slot index in frame, 0..NUM_SLOTS-1.
- frame_idx  out  FW  frame index in sequence, 0..NUM_FRAMES-1.
- active  out  1  counters are running (state RUN).
- slot_start, slot_last  out  1  first or last beat of a slot.
- frame_start, frame_last  out  1  first beat of slot 0, or last beat of the last slot.
- seq_done  out  1  one-cycle pulse after the final beat of a sequence.

## Operation
- Widths: W(N) = (N>1) ? $clog2(N) : 1. CW = W(SLOT_CYCLES), SW = W(NUM_SLOTS), FW = W(NUM_FRAMES).
  - An index never exceeds N-1. No spare MSB.
- States are IDLE and RUN.
  - ONE_SHOT=0: RUN on the first cycle after `rst` deasserts. The block never returns to IDLE.
  - ONE_SHOT=1: IDLE until `start`=1, then RUN on the next cycle with all indices 0.
- Advance occurs when active && en:
  - cyc_idx increments, and wraps to 0 at SLOT_CYCLES-1.
  - On a cyc wrap, slot_idx increments, and wraps at NUM_SLOTS-1.
  - On a slot wrap, frame_idx increments, and wraps at NUM_FRAMES-1.
- Final beat: an advance while all three indices are at their maximum.
  - All indices go to 0.
  - seq_done=1 on the next cycle.
  - ONE_SHOT=1: the state also goes to IDLE on the next cycle.
- Strobes are combinational decodes of the registered indices, gated by active. They do not depend on en.
  - slot_start = active && cyc_idx==0.
  - slot_last = active && cyc_idx==SLOT_CYCLES-1.
  - frame_start = slot_start && slot_idx==0.
  - frame_last = slot_last && slot_idx==NUM_SLOTS-1.
- Priority, highest first: rst > clear > start > advance.
  - `clear` zeroes all indices and drops a pending seq_done. State is kept.
  - `start` while in RUN is ignored. It does not restart the sequence.
- Degenerate N=1: that index is constantly 0. Its start and last strobes are both high whenever active.

## Timing
- Reset values: all indices 0, seq_done 0, state IDLE, active 0, all strobes 0.
  - ONE_SHOT=0: active=1 from the cycle after reset release.
- Index latency: an advance seen at edge k is visible from cycle k+1.
- Strobes have zero latency relative to the indices.
- seq_done is registered and lasts exactly 1 cycle.
  - In ONE_SHOT=1, seq_done and active=0 appear in the same cycle.
- Back-to-back one-shot: `start` in the same cycle as seq_done is accepted. RUN resumes on the next cycle.
- Reset mid-sequence: the next cycle shows reset values and no seq_done.
- Sequence length with en held high: SLOT_CYCLES·NUM_SLOTS·NUM_FRAMES cycles.

## Structure
- Package tdm_cnt_pkg holds:
  - function cnt_w(int n), returning W(n);
  - typedef enum {IDLE, RUN} tdm_cnt_state_t.
- Sub-module wrap_counter, instantiated three times and chained by its `last && inc` output. Its ports are:
  - parameter N;
  - clk, rst, clr, inc;
  - q[cnt_w(N)-1:0];
  - last, which is q==N-1.
- Top level holds the FSM, the seq_done register and the strobe decode.
- Elaboration-time assertion: every count parameter ≥1.

## Test plan
- Free-run, defaults, en=1: cyc_idx goes 0..7 and wraps, slot_idx increments when cyc_idx goes 7→0, and seq_done pulses exactly at cycle 512 after reset release, then repeats every 512 cycles.
- en toggled at 50% duty: indices hold on en=0 cycles and one sequence takes 1024 cycles.
- ONE_SHOT=1: active=0 and indices stay 0 until `start`; after `start`, seq_done and active=0 arrive together 512 cycles later. A `start` pulsed mid-run changes nothing.
- With `start` held high continuously, the gap between active=0 and active=1 is 1 cycle.
- `clear` at index (3,2,5): the next cycle is (0,0,0), active stays 1 and no seq_done is produced. `clear` and the final beat together: no seq_done.
- SLOT_CYCLES=1, NUM_SLOTS=1, NUM_FRAMES=3: slot_start, slot_last, frame_start and frame_last stay high, frame_idx cycles 0,1,2 and seq_done pulses every 3 cycles.
- NUM_SLOTS=5: slot_idx width is 3 and slot_idx never reaches 5.
- `rst` asserted at index (4,1,0): all outputs return to reset values on the next cycle.
